heat_col_iterator: RTL and testbench



---
 rtl/heat_col_iterator.sv | 120 ++++++++++++
 tb/tb_heat_col_iterator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/heat_col_iterator.sv
// rtl/heat_col_iterator.sv - one heat-map column: fetch samples, map to RGB332, hand pixels to the arbiter
// Optional feature macro: HEAT_COL_GRID_EN (white gridline on every 32nd row).
module heat_col_iterator #(
    parameter int          COL_X    = 0,
    parameter int          N_ROWS   = 480,
    parameter int          SCREEN_W = 640,
    parameter logic [31:0] VGA_BASE = 32'd0,
    parameter int          TEMP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inter_start,
    input  logic              comp_flag,
    output logic [8:0]        temp_rd_addr,
    input  logic [TEMP_W-1:0] temp_rd_data,
    output logic [31:0]       vga_addr,
    output logic [31:0]       vga_pxl_clr,
    output logic              col_select,
    output logic              col_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_RDWAIT  = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_ACKLOW  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [8:0] LAST_ROW = 9'(N_ROWS - 1);

    logic [2:0]  r_state;
    logic [8:0]  r_row;
    logic [31:0] r_addr;
    logic [7:0]  r_clr;
    logic        r_sel;
    logic        r_done;

    logic [1:0]  w_band;
    logic [7:0]  w_heat;
    logic [7:0]  w_clr;
    logic [31:0] w_addr;
    logic        w_unused_low;

    // Only the top two bits of the sample select the colour band.
    assign w_band       = temp_rd_data[TEMP_W-1 -: 2];
    assign w_unused_low = ^temp_rd_data[TEMP_W-3:0];

    always_comb begin
        w_heat = 8'h03;
        case (w_band)
            2'd0:    w_heat = 8'h03;
            2'd1:    w_heat = 8'h1C;
            2'd2:    w_heat = 8'hFC;
            default: w_heat = 8'hE0;
        endcase
    end

`ifdef HEAT_COL_GRID_EN
    assign w_clr = (r_row[4:0] == 5'd0) ? 8'hFF : w_heat;
`else
    assign w_clr = w_heat;
`endif

    assign w_addr = VGA_BASE + ({23'd0, r_row} * 32'(SCREEN_W)) + 32'(COL_X);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_row   <= 9'd0;
            r_addr  <= 32'd0;
            r_clr   <= 8'd0;
            r_sel   <= 1'b0;
            r_done  <= 1'b0;
        end else if (inter_start) begin
            // A restart discards any pixel still waiting for acceptance.
            r_row   <= 9'd0;
            r_sel   <= 1'b0;
            r_done  <= 1'b0;
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_IDLE;
                S_FETCH: r_state <= S_RDWAIT;
                S_RDWAIT: begin
                    r_addr  <= w_addr;
                    r_clr   <= w_clr;
                    r_sel   <= 1'b1;
                    r_state <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (comp_flag) begin
                        r_sel <= 1'b0;
                        if (r_row == LAST_ROW) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= r_row + 9'd1;
                            r_state <= S_ACKLOW;
                        end
                    end
                end
                // A held accept must drop before the next pixel is offered.
                S_ACKLOW: begin
                    if (!comp_flag) begin
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign temp_rd_addr = r_row;
    assign vga_addr     = r_addr;
    assign vga_pxl_clr  = {24'd0, r_clr};
    assign col_select   = r_sel;
    assign col_done     = r_done;

endmodule

// File: tb/tb_heat_col_iterator.sv
// tb/tb_heat_col_iterator.sv - scoreboard bench for heat_col_iterator (4-row column plus 40-row gridline column)
module tb_heat_col_iterator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0, comp_a = 1'b0;
    logic        start_b = 1'b0, comp_b = 1'b0;
    logic [8:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a = 16'd0;
    logic [15:0] rd_data_b;
    logic [31:0] addr_a, clr_a, addr_b, clr_b;
    logic        sel_a, done_a, sel_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;
    int sel_cnt_a = 0;
    int sel_cnt_b = 0;

    logic [39:0] qa[$];
    logic [39:0] qb[$];
    logic [15:0] mem_a [0:3];

    always #5 clk = ~clk;

    heat_col_iterator #(.COL_X(5), .N_ROWS(4), .SCREEN_W(640), .VGA_BASE(32'd0), .TEMP_W(16)) dut_a (
        .clk(clk), .reset(reset), .inter_start(start_a), .comp_flag(comp_a),
        .temp_rd_addr(rd_addr_a), .temp_rd_data(rd_data_a),
        .vga_addr(addr_a), .vga_pxl_clr(clr_a), .col_select(sel_a), .col_done(done_a));

    heat_col_iterator #(.COL_X(0), .N_ROWS(40), .SCREEN_W(640), .VGA_BASE(32'd0), .TEMP_W(16)) dut_b (
        .clk(clk), .reset(reset), .inter_start(start_b), .comp_flag(comp_b),
        .temp_rd_addr(rd_addr_b), .temp_rd_data(rd_data_b),
        .vga_addr(addr_b), .vga_pxl_clr(clr_b), .col_select(sel_b), .col_done(done_b));

    // Synchronous sample memory: data valid one cycle after the address.
    always @(posedge clk) rd_data_a <= mem_a[rd_addr_a[1:0]];
    assign rd_data_b = 16'h1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] exp_a(input int row, input logic [7:0] c);
        logic [31:0] a;
        a = 32'(5 + row * 640);
        return {a, c};
    endfunction

    // Monitors: pop an expected pixel on every rising col_select.
    initial begin
        logic prev;
        logic [39:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sel_a && !prev) begin
                sel_cnt_a++;
                if (qa.size() == 0) check("a_unexpected_select", 32'd1, 32'd0);
                else begin
                    e = qa.pop_front();
                    check("a_vga_addr", addr_a, e[39:8]);
                    check("a_colour", clr_a, {24'd0, e[7:0]});
                end
            end
            prev = sel_a;
        end
    end

    initial begin
        logic prev;
        logic [39:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sel_b && !prev) begin
                sel_cnt_b++;
                if (qb.size() == 0) check("b_unexpected_select", 32'd1, 32'd0);
                else begin
                    e = qb.pop_front();
                    check("b_vga_addr", addr_b, e[39:8]);
                    check("b_colour", clr_b, {24'd0, e[7:0]});
                end
            end
            prev = sel_b;
        end
    end

    task automatic wait_sel(input bit b);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if ((b ? sel_b : sel_a) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(b ? "b_select_timeout" : "a_select_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_a();
        @(negedge clk); comp_a = 1'b1;
        @(negedge clk); comp_a = 1'b0;
    endtask

    task automatic pulse_start_a();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
    endtask

    task automatic run_full_a();
        qa.push_back(exp_a(0, 8'h03));
        qa.push_back(exp_a(1, 8'h1C));
        qa.push_back(exp_a(2, 8'hFC));
        qa.push_back(exp_a(3, 8'hE0));
        pulse_start_a();
        for (int p = 0; p < 4; p++) begin
            wait_sel(1'b0);
            ack_a();
        end
        repeat (3) @(negedge clk);
        check("a_col_done", {31'd0, done_a}, 32'd1);
        check("a_select_low_when_done", {31'd0, sel_a}, 32'd0);
    endtask

    initial begin
        bit bad;
        int cnt0;
        logic [31:0] a0, c0;
        mem_a[0] = 16'h1000; mem_a[1] = 16'h5000; mem_a[2] = 16'h9000; mem_a[3] = 16'hD000;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_select", {31'd0, sel_a}, 32'd0);
        check("reset_done", {31'd0, done_a}, 32'd0);
        check("reset_addr", addr_a, 32'd0);
        check("reset_colour", clr_a, 32'd0);
        check("reset_rd_addr", {23'd0, rd_addr_a}, 32'd0);

        // Full column with prompt acks.
        cnt0 = sel_cnt_a;
        run_full_a();
        check("a_select_count", 32'(sel_cnt_a - cnt0), 32'd4);

        // Stalled arbiter for 50 cycles.
        qa.push_back(exp_a(0, 8'h03));
        pulse_start_a();
        wait_sel(1'b0);
        a0 = addr_a; c0 = clr_a; bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (sel_a !== 1'b1 || addr_a !== a0 || clr_a !== c0 || rd_addr_a !== 9'd0) bad = 1'b1;
        end
        check("stall_stable", {31'd0, bad}, 32'd0);

        // Held accept for 5 cycles advances exactly one row.
        qa.push_back(exp_a(1, 8'h1C));
        bad = 1'b0;
        comp_a = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (sel_a !== 1'b0) bad = 1'b1;
        end
        check("held_ack_no_select", {31'd0, bad}, 32'd0);
        check("held_ack_row", {23'd0, rd_addr_a}, 32'd1);
        comp_a = 1'b0;
        wait_sel(1'b0);
        check("after_held_row", {23'd0, rd_addr_a}, 32'd1);
        ack_a();

        // Restart at row 2 together with an accept.
        qa.push_back(exp_a(2, 8'hFC));
        wait_sel(1'b0);
        qa.push_back(exp_a(0, 8'h03));
        start_a = 1'b1; comp_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; comp_a = 1'b0;
        check("restart_row_zero", {23'd0, rd_addr_a}, 32'd0);
        check("restart_select_low", {31'd0, sel_a}, 32'd0);
        wait_sel(1'b0);
        check("restart_done_low", {31'd0, done_a}, 32'd0);

        // Asynchronous reset between edges while presenting.
        #2 reset = 1'b0;
        #1;
        check("async_select", {31'd0, sel_a}, 32'd0);
        check("async_done", {31'd0, done_a}, 32'd0);
        check("async_addr", addr_a, 32'd0);
        check("async_colour", clr_a, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            comp_a = k[0];
            @(negedge clk);
            if (sel_a !== 1'b0 || done_a !== 1'b0 || rd_addr_a !== 9'd0) bad = 1'b1;
        end
        comp_a = 1'b0;
        check("post_reset_idle", {31'd0, bad}, 32'd0);
        run_full_a();
        check("a_queue_drained", 32'(qa.size()), 32'd0);

        // 40-row column with constant cold samples; gridlines only when enabled.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] c;
            c = 8'h03;
`ifdef HEAT_COL_GRID_EN
            if (r == 0 || r == 32) c = 8'hFF;
`endif
            qb.push_back({32'(r * 640), c});
        end
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int p = 0; p < 40; p++) begin
            wait_sel(1'b1);
            @(negedge clk); comp_b = 1'b1;
            @(negedge clk); comp_b = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("b_col_done", {31'd0, done_b}, 32'd1);
        check("b_select_count", 32'(sel_cnt_b), 32'd40);
        check("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
